// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame width and default baud timing.
// Intended to be reused by both the receiver and a future transmitter rework.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 10416;  // 9600 baud from a 100 MHz clock

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input, plus falling-edge detect.
// Every flop resets high so an idle line never looks like an edge.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic synced,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= line;
      sync <= meta;
      prev <= sync;
    end
  end

  assign synced = sync;
  assign fall   = prev & ~sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling, one-cycle valid and
// framing-error strobes. Baud timing matches the transmitter's CLKS_PER_BIT.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .line  (rx),
    .synced(rx_s),
    .fall  (fall)
  );

  uart_state_t          state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [7:0]           data_n;
  logic                 valid_n;
  logic                 err_n;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bit_idx      <= bit_idx_n;
      shift        <= shift_n;
      rx_data      <= data_n;
      rx_valid     <= valid_n;
      rx_frame_err <= err_n;
    end
  end

  // The counter is always cleared on a state change, so it never reaches CLKS_PER_BIT.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    data_n    = rx_data;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == FULL) begin
          shift_n   = {rx_s, shift[DATA_BITS-1:1]};
          cnt_n     = '0;
          bit_idx_n = bit_idx + IDX_W'(1);
          if (bit_idx == LAST_BIT) state_n = STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == FULL) begin
          if (rx_s) begin
            data_n  = shift;
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule
